// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative MIPS32 MULT/MULTU/DIV/DIVU unit with private HI/LO;
//            divider compiled in only when MULDIV_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         hi_wen,
    input  logic         lo_wen,
    input  logic [N-1:0] wd,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t          state_q;
    logic [5:0]      cnt_q;
    logic [2*N-1:0]  acc_q;
    logic [N-1:0]    opnd_q;
    logic            neg_q;
    logic            busy_q;
    logic            done_q;
    logic [N-1:0]    hi_q;
    logic [N-1:0]    lo_q;

    logic            sa_d;
    logic            sb_d;
    logic [N-1:0]    abs_a_d;
    logic [N-1:0]    abs_b_d;
    logic [N:0]      mul_sum_d;
    logic [2*N-1:0]  prod_d;
    logic            nop_d;

    assign sa_d      = ~op[0] & inA[N-1];
    assign sb_d      = ~op[0] & inB[N-1];
    assign abs_a_d   = sa_d ? -inA : inA;
    assign abs_b_d   = sb_d ? -inB : inB;
    assign mul_sum_d = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
    assign prod_d    = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
    logic            is_div_q;
    logic            rneg_q;
    logic            dz_q;
    logic [N:0]      rem_q;
    logic [N+1:0]    diff_d;
    logic [N-1:0]    quot_d;
    logic [N-1:0]    remf_d;

    // Trial subtraction of the shifted partial remainder; a clear MSB means it fits.
    assign diff_d = {rem_q, acc_q[N-1]} - {2'b00, opnd_q};
    assign quot_d = neg_q  ? -acc_q[N-1:0] : acc_q[N-1:0];
    assign remf_d = rneg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
    assign nop_d  = 1'b0;
`else
    assign nop_d  = op[1];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            rem_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hi_wen) hi_q <= wd;
                    if (lo_wen) lo_q <= wd;
                    if (start && nop_d) begin
                        done_q <= 1'b1;
                    end else if (start) begin
                        cnt_q   <= 6'd0;
                        neg_q   <= sa_d ^ sb_d;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
`ifdef MULDIV_DIV_EN
                        is_div_q <= op[1];
                        rneg_q   <= sa_d;
                        dz_q     <= (inB == '0);
                        rem_q    <= '0;
                        acc_q    <= {{N{1'b0}}, op[1] ? abs_a_d : abs_b_d};
                        opnd_q   <= op[1] ? abs_b_d : abs_a_d;
`else
                        acc_q    <= {{N{1'b0}}, abs_b_d};
                        opnd_q   <= abs_a_d;
`endif
                    end
                end
                S_CALC: begin
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        if (!diff_d[N+1]) begin
                            rem_q        <= diff_d[N:0];
                            acc_q[N-1:0] <= {acc_q[N-2:0], 1'b1};
                        end else begin
                            rem_q        <= {rem_q[N-1:0], acc_q[N-1]};
                            acc_q[N-1:0] <= {acc_q[N-2:0], 1'b0};
                        end
                    end else
`endif
                    begin
                        acc_q <= {mul_sum_d, acc_q[N-1:1]};
                    end
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= S_FINISH;
                end
                S_FINISH: begin
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        hi_q <= remf_d;
                        lo_q <= dz_q ? {N{1'b1}} : quot_d;
                    end else
`endif
                    begin
                        hi_q <= prod_d[2*N-1:N];
                        lo_q <= prod_d[N-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Directed self-checking bench for mul_div_unit.
// Revision : 1.1 - checking task and wait-expiry check
// ============================================================================
module tb_mul_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] inA   = '0;
    logic [31:0] inB   = '0;
    logic        hi_wen = 1'b0;
    logic        lo_wen = 1'b0;
    logic [31:0] wd    = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int nvec = 0;
    int nerr = 0;
    int lat;
    int bc;
    int dcnt;

    localparam logic [1:0] c_MULT  = 2'b00;
    localparam logic [1:0] c_MULTU = 2'b01;
    localparam logic [1:0] c_DIV   = 2'b10;
    localparam logic [1:0] c_DIVU  = 2'b11;
    localparam int         c_WAIT_MAX = 60;

    mul_div_unit #(.N(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .inA    (inA),
        .inB    (inB),
        .hi_wen (hi_wen),
        .lo_wen (lo_wen),
        .wd     (wd),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit mt,
                          output int latency, output int busy_cycles);
        bit seen_done;
        start  = 1'b1;
        op     = o;
        inA    = a;
        inB    = b;
        hi_wen = mt;
        wd     = 32'h0000ABCD;
        latency     = 0;
        busy_cycles = 0;
        seen_done   = 1'b0;
        while (latency < c_WAIT_MAX) begin
            @(negedge clock);
            start  = 1'b0;
            hi_wen = 1'b0;
            latency++;
            if (busy) busy_cycles++;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (disturb && latency == 5) begin
                start  = 1'b1;
                op     = c_MULTU;
                inA    = 32'hFFFFFFFF;
                inB    = 32'hFFFFFFFF;
                hi_wen = 1'b1;
                wd     = 32'h00001234;
            end
        end
        nvec++;
        if (!seen_done) begin
            nerr++;
            $error("FAIL wait expired: no done within %0d cycles (op %0b)", c_WAIT_MAX, o);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset_hi",   hi,   32'h0);
        check("reset_lo",   lo,   32'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);

        run_op(c_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, lat, bc);
        check("multu_lat",  lat, 34);
        check("multu_busy", bc,  33);
        check("multu_hi",   hi,  32'hFFFFFFFE);
        check("multu_lo",   lo,  32'h00000001);
        check("multu_done_busy", busy, 1'b0);

        // Back-to-back: start issued in the done cycle.
        run_op(c_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, lat, bc);
        check("mult_lat", lat, 34);
        check("mult_hi",  hi,  32'hFFFFFFFF);
        check("mult_lo",  lo,  32'hFFFFFFEB);
        @(negedge clock);
        check("done_one_cycle", done, 1'b0);

        run_op(c_MULT, 32'h12345678, 32'h00000010, 1'b1, 1'b0, lat, bc);
        check("disturb_lat", lat, 34);
        check("disturb_hi",  hi,  32'h00000001);
        check("disturb_lo",  lo,  32'h23456780);
        @(negedge clock);
        check("disturb_not_queued", busy, 1'b0);

        run_op(c_MULT, 32'h80000000, 32'h80000000, 1'b0, 1'b0, lat, bc);
        check("mult_minmin_hi", hi, 32'h40000000);
        check("mult_minmin_lo", lo, 32'h00000000);

        hi_wen = 1'b1;
        wd     = 32'h00001234;
        @(negedge clock);
        hi_wen = 1'b0;
        check("mthi_hi", hi, 32'h00001234);
        check("mthi_lo", lo, 32'h00000000);
        lo_wen = 1'b1;
        wd     = 32'hCAFEF00D;
        @(negedge clock);
        lo_wen = 1'b0;
        check("mtlo_lo", lo, 32'hCAFEF00D);
        check("mtlo_hi", hi, 32'h00001234);

`ifdef MULDIV_DIV_EN
        run_op(c_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, lat, bc);
        check("div_lat", lat, 34);
        check("div_lo",  lo,  32'hFFFFFFFD);
        check("div_hi",  hi,  32'hFFFFFFFF);
        run_op(c_DIVU, 32'd100, 32'd0, 1'b0, 1'b0, lat, bc);
        check("divz_lat", lat, 34);
        check("divz_hi",  hi,  32'd100);
        check("divz_lo",  lo,  32'hFFFFFFFF);
        run_op(c_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, lat, bc);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h00000000);
        run_op(c_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, lat, bc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        run_op(c_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, lat, bc);
        check("div_negb_lo", lo, 32'hFFFFFFFD);
        check("div_negb_hi", hi, 32'd1);
        op = c_DIV;
`else
        op = c_MULT;
`endif
        // Abort an operation with reset ten cycles in.
        start = 1'b1;
        inA   = 32'd1000;
        inB   = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_hi",   hi,   32'h0);
        check("abort_lo",   lo,   32'h0);
        check("abort_busy", busy, 1'b0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcnt++;
            @(negedge clock);
        end
        check("abort_no_done", dcnt, 0);

        run_op(c_MULTU, 32'd3, 32'd5, 1'b0, 1'b0, lat, bc);
        check("mul35_lat", lat, 34);
        check("mul35_lo",  lo,  32'd15);
        check("mul35_hi",  hi,  32'd0);

`ifndef MULDIV_DIV_EN
        run_op(c_DIV, 32'd8, 32'd2, 1'b0, 1'b0, lat, bc);
        check("nop_lat",  lat, 1);
        check("nop_busy", bc,  0);
        check("nop_lo",   lo,  32'd15);
        check("nop_hi",   hi,  32'd0);
        run_op(c_DIVU, 32'd9, 32'd3, 1'b0, 1'b1, lat, bc);
        check("nop_mthi_lat", lat, 1);
        check("nop_mthi_hi",  hi,  32'h0000ABCD);
        check("nop_mthi_lo",  lo,  32'd15);
        @(negedge clock);
        check("nop_done_clear", done, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
